out_frame_streamer: RTL

- Downstream stage of the image processing engine.
- Captures the engine's addressed pixel writes (row, col, write enable, 24-bit pixel) into a 64x64 frame buffer.
- On a rising edge of the engine's done level, streams the stored frame out in raster order over a valid/ready interface for display or host readout.
- Decouples the engine's random-order writes, such as mirror column-wise, from the sequential consumer.

---
 rtl/out_frame_streamer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/out_frame_streamer.sv
// out_frame_streamer
// Captures the engine's addressed pixel writes into a 64x64 frame buffer and,
// on a rising edge of frame_done, streams the frame out in raster order over a
// valid/ready interface. The read path is RAM register -> skid -> output
// register, so a continuous stream is sustained while m_ready stays high.
// Optional feature macro: OUT_FRAME_CHECKSUM_EN (adds frame_sum / sum_valid).
module out_frame_streamer #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int ADDR_W = 6,
   parameter int PIX_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wr_row,
   input  logic [ADDR_W-1:0] wr_col,
   input  logic              wr_en,
   input  logic [PIX_W-1:0]  wr_pix,
   input  logic              frame_done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [PIX_W-1:0]  m_data,
   output logic              m_sof,
   output logic              m_last,
   output logic              busy,
   output logic              wr_err,
   output logic [7:0]        frame_cnt
`ifdef OUT_FRAME_CHECKSUM_EN
   ,
   output logic [15:0]       frame_sum,
   output logic              sum_valid
`endif
);

   localparam int DEPTH = IMG_W * IMG_H;
   localparam int AW    = 2 * ADDR_W;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREFETCH,
      S_DRAIN
   } state_t;

   // frame buffer
   logic [PIX_W-1:0] mem [DEPTH];
   logic [PIX_W-1:0] ram_data_q;

   // control
   state_t          state_q;
   logic            done_q;
   logic [AW-1:0]   ptr_q;
   logic            rd_done_q;
   logic            busy_q;
   logic            wr_err_q;
   logic [7:0]      frame_cnt_q;

   // read pipeline: RAM stage, skid stage, output stage
   logic            ram_v_q;
   logic            ram_sof_q;
   logic            ram_last_q;
   logic            skid_v_q;
   logic            skid_v_d;
   logic [PIX_W-1:0] skid_data_q;
   logic            skid_sof_q;
   logic            skid_last_q;
   logic            m_valid_q;
   logic [PIX_W-1:0] m_data_q;
   logic            m_sof_q;
   logic            m_last_q;

   logic            start;
   logic            pop;
   logic            out_load;
   logic            issue;
   logic            ram_we;

   // Handshake, skid occupancy and read-issue decisions
   always_comb begin
      start    = frame_done & ~done_q;
      pop      = m_valid_q & m_ready;
      out_load = ~m_valid_q | pop;
      ram_we   = wr_en & (state_q == S_IDLE) & ~rst;

      // RAM and skid are never both occupied: a read is only issued when the
      // skid is known to be empty next cycle, so the returning word always
      // has a place to land even if the consumer stalls.
      skid_v_d = skid_v_q;
      if (skid_v_q) begin
         if (out_load) skid_v_d = 1'b0;
      end else if (ram_v_q && !out_load) begin
         skid_v_d = 1'b1;
      end

      issue = 1'b0;
      if (state_q == S_PREFETCH) begin
         issue = 1'b1;
      end else if (state_q == S_DRAIN) begin
         issue = ~rd_done_q & ~skid_v_d;
      end
   end

   // Buffer write port (IDLE only) and registered read port
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[{wr_row, wr_col}] <= wr_pix;
      end
      if (issue) begin
         ram_data_q <= mem[ptr_q];
      end
   end

   // Frame FSM, read pointer and skid/output pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         done_q      <= frame_done;   // held-high done must fall before a new drain
         ptr_q       <= '0;
         rd_done_q   <= 1'b0;
         busy_q      <= 1'b0;
         wr_err_q    <= 1'b0;
         frame_cnt_q <= '0;
         ram_v_q     <= 1'b0;
         ram_sof_q   <= 1'b0;
         ram_last_q  <= 1'b0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_sof_q  <= 1'b0;
         skid_last_q <= 1'b0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_sof_q     <= 1'b0;
         m_last_q    <= 1'b0;
      end else begin
         done_q <= frame_done;

         // read issue
         ram_v_q <= issue;
         if (issue) begin
            ram_sof_q  <= (ptr_q == '0);
            ram_last_q <= (ptr_q == LAST_ADDR);
            ptr_q      <= ptr_q + 1'b1;    // wraps back to 0 after the last read
            if (ptr_q == LAST_ADDR) rd_done_q <= 1'b1;
         end

         // RAM word parks in the skid when the output register cannot take it
         skid_v_q <= skid_v_d;
         if (ram_v_q && !out_load) begin
            skid_data_q <= ram_data_q;
            skid_sof_q  <= ram_sof_q;
            skid_last_q <= ram_last_q;
         end

         // output register: skid has priority since it holds the older word
         if (out_load) begin
            if (skid_v_q) begin
               m_valid_q <= 1'b1;
               m_data_q  <= skid_data_q;
               m_sof_q   <= skid_sof_q;
               m_last_q  <= skid_last_q;
            end else if (ram_v_q) begin
               m_valid_q <= 1'b1;
               m_data_q  <= ram_data_q;
               m_sof_q   <= ram_sof_q;
               m_last_q  <= ram_last_q;
            end else begin
               m_valid_q <= 1'b0;
            end
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_PREFETCH;
                  busy_q    <= 1'b1;
                  rd_done_q <= 1'b0;
               end
            end
            S_PREFETCH: begin
               if (wr_en || start) wr_err_q <= 1'b1;
               state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (wr_en || start) wr_err_q <= 1'b1;
               if (pop && m_last_q) begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  frame_cnt_q <= frame_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef OUT_FRAME_CHECKSUM_EN
   logic [15:0] frame_sum_q;
   logic        sum_valid_q;
   logic [15:0] beat_sum;

   // Per-beat R+G+B contribution
   always_comb begin
      beat_sum = 16'(m_data_q[23:16]) + 16'(m_data_q[15:8]) + 16'(m_data_q[7:0]);
   end

   // Frame checksum: cleared on start, accumulated on every accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_sum_q <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         sum_valid_q <= pop & m_last_q;
         if (state_q == S_IDLE && start) begin
            frame_sum_q <= '0;
         end else if (pop) begin
            frame_sum_q <= frame_sum_q + beat_sum;
         end
      end
   end

   assign frame_sum = frame_sum_q;
   assign sum_valid = sum_valid_q;
`endif

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_sof     = m_sof_q;
   assign m_last    = m_last_q;
   assign busy      = busy_q;
   assign wr_err    = wr_err_q;
   assign frame_cnt = frame_cnt_q;

endmodule
